// File: rtl/bomberman_sfx_event_pio.sv
// ---------------------------------------------------------------------------
// bomberman_sfx_event_pio
//
// Avalon-MM slave input port that returns game-fabric event lines (bomb
// placed, bomb exploded, player hit) to the CPU. The event lines are
// synchronized, edges are latched in a write-1-to-clear capture register,
// a level interrupt is raised for unmasked captured edges, and a saturating
// event counter lets software detect events it missed.
//
// Register map (address):
//   0  data        R   synchronized event lines (writes ignored)
//   1  irqmask     RW  per-line interrupt enable
//   2  evcount     R   saturating count of detect cycles; any write clears
//   3  edgecapture R   captured edges; write 1 to a bit to clear it
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   address    register select
//   chipselect slave select
//   write_n    active-low write strobe (write = chipselect & ~write_n)
//   writedata  write data
//   in_port    asynchronous event lines from game logic
//   readdata   registered read data, upper bits zero
//   irq        level interrupt, |(edgecapture & irqmask)
// ---------------------------------------------------------------------------
module bomberman_sfx_event_pio #(
  parameter int WIDTH     = 3,  // number of event lines, 1..8
  parameter int EDGE_TYPE = 0   // 0 = rising, 1 = falling, 2 = any
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_CNT  = 2'd2;
  localparam logic [1:0] ADDR_CAP  = 2'd3;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [1:0]       warm;
  logic [WIDTH-1:0] irqmask;
  logic [7:0]       evcount;
  logic [WIDTH-1:0] edgecapture;

  logic             wr_en;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] detect;
  logic [7:0]       ev_base;
  logic [7:0]       ev_next;
  logic [31:0]      rd_mux;

  // Only the low WIDTH bits of writedata carry register content.
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:WIDTH];

  assign wr_en = chipselect & ~write_n;

  // Edge detection. Detect is held off until the warm-up counter saturates so
  // the synchronizer filling after reset never looks like an event.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    rise   = sync2 & ~prev;
    fall   = ~sync2 & prev;
    detect = '0;
    if (warm == 2'd3) begin
      if (EDGE_TYPE == 0)      detect = rise;
      else if (EDGE_TYPE == 1) detect = fall;
      else                     detect = rise | fall;
    end
  end

  // Event counter: a write clears first, then the detect increment applies,
  // so a clear colliding with an event leaves the count at 1.
  always_comb begin
    ev_base = (wr_en && address == ADDR_CNT) ? 8'd0 : evcount;
    ev_next = ev_base;
    if (|detect && ev_base != 8'hFF) ev_next = ev_base + 8'd1;
  end

  always_comb begin
    rd_mux = '0;
    unique case (address)
      ADDR_DATA: rd_mux = 32'(sync2);
      ADDR_MASK: rd_mux = 32'(irqmask);
      ADDR_CNT:  rd_mux = 32'(evcount);
      ADDR_CAP:  rd_mux = 32'(edgecapture);
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1       <= '0;
      sync2       <= '0;
      prev        <= '0;
      warm        <= '0;
      irqmask     <= '0;
      evcount     <= '0;
      edgecapture <= '0;
      readdata    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, which is what makes sync1 -> sync2 ->
      // prev a real three-stage pipeline.
      sync1   <= in_port;
      sync2   <= sync1;
      prev    <= sync2;
      if (warm != 2'd3) warm <= warm + 2'd1;

      if (wr_en && address == ADDR_MASK) irqmask <= writedata[WIDTH-1:0];

      evcount <= ev_next;

      // Set wins over a same-cycle clear.
      if (wr_en && address == ADDR_CAP)
        edgecapture <= (edgecapture & ~writedata[WIDTH-1:0]) | detect;
      else
        edgecapture <= edgecapture | detect;

      readdata <= rd_mux;
    end
  end

  assign irq = |(edgecapture & irqmask);

endmodule
